// File: rtl/mux_pipe_sel_pkg.sv
// Shared constants, FSM state encoding and the select-width helper for the
// registered N:1 selector.
package mux_pipe_sel_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Smallest r with 2**r >= n; kept local so it is usable in parameter defaults.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_comb_n.sv
// Unregistered N:1 select with an out-of-range flag; an invalid select yields
// zero data so nothing stale leaks downstream.
module mux_comb_n
  import mux_pipe_sel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        sel_data_o,
  output logic                    sel_err_o
);

  always_comb begin
    sel_data_o = '0;
    sel_err_o  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        sel_data_o = in_data_i[k*WIDTH +: WIDTH];
        sel_err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_sel.sv
// Registered N:1 selector with valid/ready on both sides and a one-entry skid
// buffer so in_ready_o never depends combinationally on out_ready_i.
//
//   state    | meaning
//   ST_EMPTY | output register empty, skid empty
//   ST_BUSY  | output register holds a beat, skid empty
//   ST_FULL  | output register and skid both hold a beat, in_ready_o low
module mux_pipe_sel
  import mux_pipe_sel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    out_err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] out_data_q, skid_data_q;
  logic [SEL_W-1:0] out_sel_q, skid_sel_q;
  logic             out_err_q, skid_err_q;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             in_fire, out_fire;
  logic             load_out, load_skid, out_from_skid;

  mux_comb_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data_i (in_data_i),
    .sel_i     (in_sel_i),
    .sel_data_o(sel_data),
    .sel_err_o (sel_err)
  );

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
  assign out_err_o   = out_err_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_out = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          out_from_skid = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_q <= sel_data;
        out_sel_q  <= in_sel_i;
        out_err_q  <= sel_err;
      end else if (out_from_skid) begin
        out_data_q <= skid_data_q;
        out_sel_q  <= skid_sel_q;
        out_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= sel_data;
        skid_sel_q  <= in_sel_i;
        skid_err_q  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed and scoreboarded checks of mux_pipe_sel: a 4-input instance and a
// 5-input instance for out-of-range selects.
module tb_mux_pipe_sel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] d4;
  logic [1:0]   s4, os4;
  logic         v4, ir4, oe4, ov4, or4;
  logic [31:0]  od4;

  logic [159:0] d5;
  logic [2:0]   s5, os5;
  logic         v5, ir5, oe5, ov5, or5;
  logic [31:0]  od5;

  int n_checks = 0;
  int n_fail   = 0;

  mux_pipe_sel #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(d4), .in_sel_i(s4), .in_valid_i(v4), .in_ready_o(ir4),
    .out_data_o(od4), .out_sel_o(os4), .out_err_o(oe4), .out_valid_o(ov4),
    .out_ready_i(or4)
  );

  mux_pipe_sel #(.WIDTH(32), .NUM_IN(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(d5), .in_sel_i(s5), .in_valid_i(v5), .in_ready_o(ir5),
    .out_data_o(od5), .out_sel_o(os5), .out_err_o(oe5), .out_valid_o(ov5),
    .out_ready_i(or5)
  );

  localparam logic [127:0] PAT4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [159:0] PAT5 = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL rst_init_valid: got %b want 0", ov4); end
    n_checks++; if (od4 !== 32'h0) begin n_fail++; $display("FAIL rst_init_data: got %h want 0", od4); end
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL rst_init_ready: got %b want 1", ir4); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d4 = PAT4; s4 = 2'd1; v4 = 1'b1; or4 = 1'b0;
    d5 = PAT5; s5 = 3'd7; v5 = 1'b1; or5 = 1'b0;
    @(negedge clk);
    v4 = 1'b0; v5 = 1'b0;
    n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL rst_busy_valid: got %b want 1", ov4); end
    n_checks++; if (od4 !== 32'h22222222) begin n_fail++; $display("FAIL rst_busy_data: got %h want 22222222", od4); end
    n_checks++; if (oe5 !== 1'b1) begin n_fail++; $display("FAIL rst_busy_err: got %b want 1", oe5); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", ov4); end
    n_checks++; if (od4 !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: got %h want 0", od4); end
    n_checks++; if (os4 !== 2'd0) begin n_fail++; $display("FAIL rst_async_sel: got %0d want 0", os4); end
    n_checks++; if (oe5 !== 1'b0) begin n_fail++; $display("FAIL rst_async_err: got %b want 0", oe5); end
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid5: got %b want 0", ov5); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", ir4); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b want 0", ov4); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222;
    exp[2] = 32'h33333333; exp[3] = 32'h44444444;
    d4 = PAT4; or4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i-1, ov4); end
        n_checks++; if (od4 !== exp[i-1]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i-1, od4, exp[i-1]); end
        n_checks++; if (os4 !== 2'(i-1)) begin n_fail++; $display("FAIL stream_sel[%0d]: got %0d want %0d", i-1, os4, i-1); end
      end
      n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ir4); end
      v4 = (i < 4);
      s4 = 2'(i);
    end
    @(negedge clk);
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", ov4); end
  endtask

  task automatic test_backpressure();
    d4 = PAT4; s4 = 2'd2; v4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    n_checks++; if (od4 !== 32'h33333333) begin n_fail++; $display("FAIL bp_first: got %h want 33333333", od4); end
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_busy: got %b want 1", ir4); end
    s4 = 2'd3; or4 = 1'b0;
    @(negedge clk);
    n_checks++; if (od4 !== 32'h33333333) begin n_fail++; $display("FAIL bp_hold1: got %h want 33333333", od4); end
    n_checks++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", ir4); end
    s4 = 2'd1; d4 = {4{32'hDEADBEEF}};
    @(negedge clk);
    n_checks++; if (od4 !== 32'h33333333) begin n_fail++; $display("FAIL bp_hold2: got %h want 33333333", od4); end
    n_checks++; if (os4 !== 2'd2) begin n_fail++; $display("FAIL bp_hold_sel: got %0d want 2", os4); end
    n_checks++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold: got %b want 0", ir4); end
    d4 = PAT4; or4 = 1'b1;
    @(negedge clk);
    n_checks++; if (od4 !== 32'h44444444) begin n_fail++; $display("FAIL bp_skid_out: got %h want 44444444", od4); end
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", ir4); end
    @(negedge clk);
    v4 = 1'b0;
    n_checks++; if (od4 !== 32'h22222222) begin n_fail++; $display("FAIL bp_third: got %h want 22222222", od4); end
    n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL bp_third_valid: got %b want 1", ov4); end
    @(negedge clk);
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", ov4); end
  endtask

  task automatic test_out_of_range();
    logic [2:0]  sels [4];
    logic [31:0] exp_d [4];
    logic        exp_e [4];
    sels[0] = 3'd6; exp_d[0] = 32'h0;        exp_e[0] = 1'b1;
    sels[1] = 3'd4; exp_d[1] = 32'hA0000004; exp_e[1] = 1'b0;
    sels[2] = 3'd5; exp_d[2] = 32'h0;        exp_e[2] = 1'b1;
    sels[3] = 3'd0; exp_d[3] = 32'hA0000000; exp_e[3] = 1'b0;
    d5 = PAT5; or5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (od5 !== exp_d[i-1]) begin n_fail++; $display("FAIL oor_data[%0d]: got %h want %h", i-1, od5, exp_d[i-1]); end
        n_checks++; if (oe5 !== exp_e[i-1]) begin n_fail++; $display("FAIL oor_err[%0d]: got %b want %b", i-1, oe5, exp_e[i-1]); end
        n_checks++; if (os5 !== sels[i-1]) begin n_fail++; $display("FAIL oor_sel[%0d]: got %0d want %0d", i-1, os5, sels[i-1]); end
        n_checks++; if (ov5 !== 1'b1) begin n_fail++; $display("FAIL oor_valid[%0d]: got %b want 1", i-1, ov5); end
      end
      v5 = (i < 4);
      if (i < 4) s5 = sels[i];
    end
    @(negedge clk);
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL oor_drain: got %b want 0", ov5); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qd [$];
    logic [1:0]  qs [$];
    int pushed;
    bit push, pop;
    pushed = 0;
    v4 = 1'b0; or4 = 1'b0;
    for (int cyc = 0; cyc < 400 && (pushed < 20 || qd.size() > 0); cyc++) begin
      @(negedge clk);
      n_checks++; if (ir4 !== (qd.size() < 2)) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", cyc, ir4, qd.size() < 2); end
      n_checks++; if (ov4 !== (qd.size() > 0)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", cyc, ov4, qd.size() > 0); end
      if (qd.size() > 0) begin
        n_checks++; if (od4 !== qd[0] || os4 !== qs[0]) begin
          n_fail++; $display("FAIL b2b_data c%0d: got %h/%0d want %h/%0d", cyc, od4, os4, qd[0], qs[0]);
        end
      end
      d4  = {$urandom, $urandom, $urandom, $urandom};
      s4  = 2'($urandom_range(0, 3));
      v4  = (pushed < 20);
      or4 = 1'($urandom_range(0, 1));
      push = v4 && (qd.size() < 2);
      pop  = or4 && (qd.size() > 0);
      if (pop) begin
        void'(qd.pop_front());
        void'(qs.pop_front());
      end
      if (push) begin
        qd.push_back(d4[s4*32 +: 32]);
        qs.push_back(s4);
        pushed++;
      end
    end
    v4 = 1'b0;
    @(negedge clk);
    n_checks++; if (pushed != 20 || qd.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: pushed %0d left %0d want 20/0", pushed, qd.size()); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", ov4); end
  endtask

  initial begin
    d4 = '0; s4 = '0; v4 = 1'b0; or4 = 1'b0;
    d5 = '0; s5 = '0; v5 = 1'b0; or5 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t want below 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux_pipe_sel.md
Name: mux_pipe_sel

Overview:
- Parametrised N-input, W-bit selector with a registered output stage and valid/ready handshake on both sides.
- Generalises the 32-bit 4:1 datapath mux to any width and input count.
- Adds out-of-range select detection and a skid buffer, so it can sit between pipeline stages of the miniRISC core (e.g. ALU operand / writeback-source select) without breaking the ready path.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- NUM_IN, 4: number of data inputs; minimum 2.
- SEL_W, $clog2(NUM_IN): select width; derived, never overridden.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_DATA  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- IN_SEL  input  SEL_W  binary select, sampled with the input transfer
- IN_VALID  input  1  upstream has a selection to transfer
- IN_READY  output  1  block can accept a transfer this cycle
- OUT_DATA  output  WIDTH  selected data
- OUT_SEL  output  SEL_W  select value that produced OUT_DATA
- OUT_ERR  output  1  IN_SEL was >= NUM_IN for this beat
- OUT_VALID  output  1  output beat available
- OUT_READY  input  1  downstream accepts the output beat

Behaviour:
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Combinational core produces sel_data = IN_DATA[IN_SEL]. If IN_SEL >= NUM_IN (possible only when NUM_IN is not a power of two), sel_data = 0 and sel_err = 1.
- Storage:
  - Output register {data, sel, err}, which drives the OUT_* ports.
  - One skid register with the same fields plus skid_valid.
- IN_READY = ~skid_valid. It is a registered term and has no combinational path from OUT_READY.
- Latency is 1 cycle from in_fire to OUT_VALID. Throughput is 1 beat per cycle while OUT_READY = 1.
- States, with transitions evaluated at the rising edge of CLK:
  - EMPTY (OUT_VALID=0, skid empty):
    - in_fire: load output register, go to BUSY.
  - BUSY (OUT_VALID=1, skid empty):
    - in_fire & out_fire: load output register with the new beat, stay in BUSY.
    - in_fire & ~out_fire: load skid register, go to FULL.
    - ~in_fire & out_fire: go to EMPTY.
    - neither: hold.
  - FULL (OUT_VALID=1, skid valid, IN_READY=0):
    - out_fire: move skid to output register, clear skid_valid, go to BUSY.
    - otherwise: hold.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_SEL and OUT_ERR are stable.
- Beats are never dropped, duplicated or reordered.
- IN_DATA and IN_SEL are don't-care when in_fire=0. Changing them then has no effect on any output.
- Reset (RST_N=0, asynchronous; the registers below change immediately, without waiting for CLK):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, OUT_ERR=0.
  - skid_valid=0, so IN_READY=1.
  - Reset mid-transfer discards both the output and the skid beat.
  - Release is synchronous to CLK by the system reset scheme.
- An out-of-range beat is an ordinary beat: it is handshaked and flows through skid and output like any other. OUT_ERR travels with it.

Decomposition:
- Shared include file (defines header): CLOG2 function, default WIDTH/NUM_IN constants, and encoding of the FSM state (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2). The implementation may derive state from {OUT_VALID, skid_valid} instead; the encoding is documentation only.
- Sub-module mux_comb_n (WIDTH, NUM_IN): purely combinational N:1 mux with the out-of-range flag. It is reusable wherever the core needs an unregistered select.
- mux_pipe_sel instantiates mux_comb_n once and adds the handshake registers.

Test Plan:
- Reset/idle: assert RST_N=0 mid-BUSY with OUT_VALID=1 -> OUT_VALID, OUT_DATA, OUT_ERR go to 0 immediately without a clock edge; IN_READY=1 after release.
- Streaming, WIDTH=32, NUM_IN=4: inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, OUT_READY=1, IN_SEL=0,1,2,3 on consecutive cycles -> OUT_DATA equals the same sequence, each one cycle after its in_fire, with no bubbles.
- Backpressure: stream IN_SEL=2,3,1 while OUT_READY=0 from the cycle after the first accept:
  - OUT_DATA holds 0x33333333.
  - The second beat is accepted into skid, then IN_READY drops to 0.
  - After OUT_READY=1, outputs 0x33333333, 0x44444444, 0x22222222 appear in order, and IN_READY returns to 1 one cycle after the first out_fire.
- Out of range, NUM_IN=5, SEL_W=3: IN_SEL=6 -> OUT_DATA=0, OUT_ERR=1, OUT_SEL=6. Next beat IN_SEL=4 -> input 4 data, OUT_ERR=0.
- Simultaneous fire in BUSY: in_fire and out_fire in the same cycle for 20 random beats, with a random OUT_READY duty of 50% -> scoreboard shows an exact in-order match and stable outputs under stall.
